// File: rtl/atm_controller.sv
// ATM transaction controller with a 10-entry account table (PIN and balance).
// Each transaction runs IDLE -> AUTH -> MENU -> EXEC/ERROR -> IDLE and reports
// the resulting balance and a success flag on the final edge.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE   (7) | latch request fields on the next edge
// AUTH   (0) | check account range and PIN against the table
// MENU   (1) | dispatch to the requested operation or to ERROR
// ERROR  (2) | report failure, table untouched
// BALANCE(3) | report stored balance
// WITHDRAW(4)| subtract amount if funds suffice
// DEPOSIT(5) | add amount unless the 32-bit balance would overflow
// CHANGE_PIN(6)| replace stored PIN, report stored balance
module atm_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  operation_i,
    input  logic [3:0]  acc_num_i,
    input  logic [15:0] pin_i,
    input  logic [15:0] new_pin_i,
    input  logic [31:0] amount_i,
    input  logic        language_i,
    output logic [31:0] balance_o,
    output logic        success_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_AUTH       = 3'd0,
        S_MENU       = 3'd1,
        S_ERROR      = 3'd2,
        S_BALANCE    = 3'd3,
        S_WITHDRAW   = 3'd4,
        S_DEPOSIT    = 3'd5,
        S_CHANGE_PIN = 3'd6,
        S_IDLE       = 3'd7
    } state_t;

    localparam logic [15:0] RST_PIN [10] = '{
        16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
        16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
    };
    localparam logic [31:0] RST_BAL [10] = '{
        32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000,
        32'd6000, 32'd7000, 32'd8000, 32'd9000, 32'd10000
    };

    state_t      state_q, state_d;

    logic [2:0]  op_q;
    logic        acc_ok_q;
    logic [3:0]  idx_q;
    logic [15:0] pin_in_q;
    logic [15:0] new_pin_q;
    logic [31:0] amount_q;
    // Language choice is held for the display front end; it never alters results here.
    logic        lang_unused_q;
    logic        auth_ok_q;

    logic [15:0] pin_tab_q [10];
    logic [31:0] bal_tab_q [10];

    logic [31:0] balance_q;
    logic        success_q;

    logic        acc_in_range;
    logic [31:0] stored_bal;
    logic [32:0] dep_sum;
    logic        wr_bal;
    logic        wr_pin;
    logic [31:0] new_bal;
    logic [31:0] res_bal;
    logic        res_succ;

    assign acc_in_range = (acc_num_i >= 4'd1) && (acc_num_i <= 4'd10);
    assign stored_bal   = bal_tab_q[idx_q];
    assign dep_sum      = {1'b0, stored_bal} + {1'b0, amount_q};

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed walk through the sequence; MENU is the only branch point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_AUTH;
            S_AUTH: state_d = S_MENU;
            S_MENU: begin
                if (auth_ok_q && (op_q >= 3'd3) && (op_q <= 3'd6)) begin
                    state_d = state_t'(op_q);
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result of the execution state, committed on the edge back to IDLE.
    always_comb begin
        wr_bal   = 1'b0;
        wr_pin   = 1'b0;
        new_bal  = stored_bal;
        res_bal  = 32'd0;
        res_succ = 1'b0;
        case (state_q)
            S_BALANCE: begin
                res_bal  = stored_bal;
                res_succ = 1'b1;
            end
            S_WITHDRAW: begin
                if (amount_q <= stored_bal) begin
                    new_bal  = stored_bal - amount_q;
                    wr_bal   = 1'b1;
                    res_bal  = new_bal;
                    res_succ = 1'b1;
                end
            end
            S_DEPOSIT: begin
                if (!dep_sum[32]) begin
                    new_bal  = dep_sum[31:0];
                    wr_bal   = 1'b1;
                    res_bal  = new_bal;
                    res_succ = 1'b1;
                end
            end
            S_CHANGE_PIN: begin
                wr_pin   = 1'b1;
                res_bal  = stored_bal;
                res_succ = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Request latch, authentication, account table and reported results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= 3'd0;
            acc_ok_q      <= 1'b0;
            idx_q         <= 4'd0;
            pin_in_q      <= 16'd0;
            new_pin_q     <= 16'd0;
            amount_q      <= 32'd0;
            lang_unused_q <= 1'b0;
            auth_ok_q     <= 1'b0;
            balance_q     <= 32'd0;
            success_q     <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                pin_tab_q[i] <= RST_PIN[i];
                bal_tab_q[i] <= RST_BAL[i];
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    op_q          <= operation_i;
                    acc_ok_q      <= acc_in_range;
                    // Out-of-range accounts park on entry 0; auth fails regardless.
                    idx_q         <= acc_in_range ? (acc_num_i - 4'd1) : 4'd0;
                    pin_in_q      <= pin_i;
                    new_pin_q     <= new_pin_i;
                    amount_q      <= amount_i;
                    lang_unused_q <= language_i;
                end
                S_AUTH: begin
                    auth_ok_q <= acc_ok_q && (pin_in_q == pin_tab_q[idx_q]);
                end
                S_MENU: begin
                end
                default: begin
                    balance_q <= res_bal;
                    success_q <= res_succ;
                    if (wr_bal) begin
                        bal_tab_q[idx_q] <= new_bal;
                    end
                    if (wr_pin) begin
                        pin_tab_q[idx_q] <= new_pin_q;
                    end
                end
            endcase
        end
    end

    assign balance_o = balance_q;
    assign success_o = success_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: stimulus pushes expected results from a
// behavioural account model; a monitor pops them at each transaction completion.
module tb_atm_controller;

    logic        clk;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    atm_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .operation_i (operation),
        .acc_num_i   (acc_num),
        .pin_i       (pin),
        .new_pin_i   (new_pin),
        .amount_i    (amount),
        .language_i  (language),
        .balance_o   (balance),
        .success_o   (success),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [31:0] bal;
        logic        succ;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     mpin [1:10];
    longint mbal [1:10];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mpin[1] = 1234; mpin[2] = 2345; mpin[3] = 3456; mpin[4] = 4567; mpin[5] = 5678;
        mpin[6] = 6789; mpin[7] = 7890; mpin[8] = 8901; mpin[9] = 9012; mpin[10] = 7123;
        for (int n = 1; n <= 10; n++) mbal[n] = 1000 * n;
    endtask

    // Reference behaviour: what the customer should see for this request.
    task automatic push_expect(input int op, input int acc, input int p, input int np, input longint amt);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if (acc >= 1 && acc <= 10) begin
            if (mpin[acc] == p && op >= 3 && op <= 6) ok = 1'b1;
        end
        e.st = 2; e.bal = 32'd0; e.succ = 1'b0;
        if (ok) begin
            e.st = op;
            case (op)
                3: begin e.bal = mbal[acc][31:0]; e.succ = 1'b1; end
                4: begin
                    if (amt <= mbal[acc]) begin
                        mbal[acc] = mbal[acc] - amt;
                        e.bal = mbal[acc][31:0]; e.succ = 1'b1;
                    end
                end
                5: begin
                    if (mbal[acc] + amt <= 64'hFFFF_FFFF) begin
                        mbal[acc] = mbal[acc] + amt;
                        e.bal = mbal[acc][31:0]; e.succ = 1'b1;
                    end
                end
                default: begin
                    mpin[acc] = np;
                    e.bal = mbal[acc][31:0]; e.succ = 1'b1;
                end
            endcase
        end
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic txn(input int op, input int acc, input int p, input int np,
                       input longint amt, input bit scramble);
        operation = op[2:0];
        acc_num   = acc[3:0];
        pin       = p[15:0];
        new_pin   = np[15:0];
        amount    = amt[31:0];
        language  = $urandom_range(0, 1);
        push_expect(op, acc, p, np, amt);
        @(posedge clk); #1;
        if (scramble) begin
            operation = $urandom_range(0, 7);
            acc_num   = $urandom_range(0, 15);
            pin       = $urandom;
            new_pin   = $urandom;
            amount    = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: a completion is IDLE entered from an execution or error state.
    int prev_st = 7;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_st = 7;
        end else begin
            if (state == 3'd7 && prev_st >= 2 && prev_st <= 6) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_state", prev_st, e.st);
                    chk("balance", balance, e.bal);
                    chk("success", success, e.succ);
                end
            end
            prev_st = state;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, pending %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, op, p, np, mode;
        longint amt;
        rst = 1'b1;
        operation = 3'd0; acc_num = 4'd0; pin = 16'd0; new_pin = 16'd0;
        amount = 32'd0; language = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state, 7);
        chk("reset_balance", balance, 0);
        chk("reset_success", success, 0);
        rst = 1'b0;
        chk("release_state", state, 7);

        for (int n = 1; n <= 10; n++) txn(3, n, mpin[n], 0, 0, 1'b1);
        for (int n = 1; n <= 10; n++) txn(5, n, mpin[n], 0, 1000, 1'b1);
        for (int n = 1; n <= 10; n++) txn(4, n, mpin[n], 0, 500, 1'b1);

        txn(4, 1, 1235, 0, 500, 1'b1);
        txn(3, 1, 1234, 0, 0, 1'b1);
        txn(4, 1, 1234, 0, 5000, 1'b1);
        txn(3, 1, 1234, 0, 0, 1'b0);
        txn(3, 0, 1234, 0, 0, 1'b1);
        txn(3, 11, 1234, 0, 0, 1'b1);
        txn(2, 2, 2345, 0, 0, 1'b1);
        txn(6, 1, 1234, 5678, 0, 1'b1);
        txn(3, 1, 1234, 0, 0, 1'b1);
        txn(3, 1, 5678, 0, 0, 1'b1);
        txn(5, 7, 7890, 0, 300, 1'b0);
        txn(5, 7, 7890, 0, 300, 1'b0);
        txn(5, 3, 3456, 0, 64'hFFFF_FFFF, 1'b1);
        txn(4, 4, 4567, 0, mbal[4], 1'b1);

        // Reset in MENU of a deposit: no completion, table back to defaults.
        operation = 3'd5; acc_num = 4'd2; pin = 16'd2345; amount = 32'd777;
        @(posedge clk);
        @(posedge clk); #1;
        chk("menu_before_reset", state, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("state_after_reset", state, 7);
        chk("balance_after_reset", balance, 0);
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= 10; n++) txn(3, n, mpin[n], 0, 0, 1'b1);

        for (int k = 0; k < 60; k++) begin
            op  = (($urandom % 4) == 0) ? $urandom_range(0, 7) : $urandom_range(3, 6);
            acc = (($urandom % 6) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 10);
            if (acc >= 1 && acc <= 10 && ($urandom % 5) != 0) p = mpin[acc];
            else p = $urandom & 16'hFFFF;
            np = $urandom & 16'hFFFF;
            mode = $urandom_range(0, 3);
            if (mode == 0)      amt = $urandom;
            else if (mode == 1) amt = 64'hFFFF_FFFF - $urandom_range(0, 20000);
            else                amt = $urandom_range(0, 20000);
            txn(op, acc, p, np, amt, 1'b1);
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
